gf180mcu_ocd_io_pwrseq: RTL and testbench
=========================================

Name: gf180mcu_ocd_io_pwrseq

Overview:
- Synchronous power-up/power-down sequencer for one IO ring segment: the ring of pad, filler and corner cells carrying the DVDD, DVSS, VDD and VSS rails.
- Drives the core-rail (VDD) and IO-rail (DVDD) switch enables in order and monitors the power-good comparators.
- Controls pad isolation so pads never toggle while a rail is unpowered.
- Sits in the always-on domain beside the ring; its outputs feed the rail switches and the ring isolation net.

Parameters:
- CNT_W, 16, width of the shared delay/timeout counter.
- SETTLE_CYC, 100, cycles to wait after power-good before the next step; also the wait after each rail is switched off.
- TIMEOUT_CYC, 1000, maximum cycles to wait for power-good before declaring a fault.
- ISO_DLY, 16, cycles between rail-stable and isolation release, and between isolation assert and rail-off.

Ports:
- CLK  in  1  sequencer clock, always-on domain.
- RST  in  1  synchronous, active-high reset.
- PWR_REQ  in  1  level request: 1 = ring powered, 0 = ring off.
- FAULT_CLR  in  1  single-cycle pulse to clear a latched fault.
- VDD_PG  in  1  core-rail power-good; asynchronous.
- DVDD_PG  in  1  IO-rail power-good; asynchronous.
- VDD_EN  out  1  core-rail switch enable.
- DVDD_EN  out  1  IO-rail switch enable.
- ISO_N  out  1  pad isolation; 0 = isolated/held, 1 = released.
- PWR_RDY  out  1  ring fully powered and released.
- FAULT  out  1  latched sequencing fault.
- STATE  out  4  current state encoding, for debug.

Behaviour:
- Interface rules:
  - Single clock CLK. RST is synchronous and active-high.
  - All outputs are registered Moore outputs: they reflect the state entered on the previous edge.
- Reset values:
  - VDD_EN=0, DVDD_EN=0, ISO_N=0, PWR_RDY=0, FAULT=0, STATE=OFF.
  - Counter=0; synchronizers cleared.
  - RST mid-sequence drops all enables on the next edge. There is no graceful ramp-down on reset.
- VDD_PG and DVDD_PG pass through 2-flop synchronizers (2-cycle latency). FSM decisions use only the synchronized vpg/dpg.
- Counter: clears on every state change and increments each cycle otherwise. A "wait N" step completes on the cycle the count equals N-1. Requires all N ≥ 1 and N ≤ 2^CNT_W.
- States and outputs:
  - OFF=0: all outputs 0. Go to CORE_UP when PWR_REQ=1.
  - CORE_UP=1: VDD_EN=1. On vpg go to CORE_SET. If count reaches TIMEOUT_CYC-1 without vpg, go to FLT.
  - CORE_SET=2: VDD_EN=1. Wait SETTLE_CYC, then go to IO_UP.
  - IO_UP=3: VDD_EN=1, DVDD_EN=1. On dpg go to IO_SET. On timeout go to FLT.
  - IO_SET=4: wait SETTLE_CYC, then go to ISO_REL.
  - ISO_REL=5: wait ISO_DLY, then go to ON.
  - ON=6: ISO_N=1, PWR_RDY=1, both enables 1.
  - ISO_SET=7: ISO_N=0, PWR_RDY=0, enables held at 1. Wait ISO_DLY, then go to IO_DN.
  - IO_DN=8: DVDD_EN=0, VDD_EN=1. Wait SETTLE_CYC, then go to CORE_DN.
  - CORE_DN=9: both enables 0. Wait SETTLE_CYC, then go to OFF.
  - FLT=10: VDD_EN=0, DVDD_EN=0, ISO_N=0, PWR_RDY=0, FAULT=1.
- Transitions out of the normal path:
  - From ON: PWR_REQ=0 goes to ISO_SET. Loss of vpg or dpg goes to FLT; loss of power-good takes priority over PWR_REQ=0 in the same cycle.
  - PWR_REQ=0 during CORE_UP or CORE_SET goes to CORE_DN.
  - PWR_REQ=0 during IO_UP, IO_SET or ISO_REL goes to IO_DN.
  - Loss of vpg in any state after CORE_UP, except the down states, goes to FLT.
  - PWR_REQ=1 during any down state is ignored until OFF is reached. OFF then restarts the sequence on the next cycle.
  - Timeout has priority over power-good arriving in the same cycle only if vpg/dpg is still 0. If vpg/dpg=1 on the timeout cycle, the step succeeds.
- Fault handling:
  - FLT exits to OFF only when FAULT_CLR=1 and PWR_REQ=0 in the same cycle.
  - FAULT_CLR in any other state, or with PWR_REQ=1, is ignored.

Decomposition:
- Package gf180mcu_ocd_io_pwrseq_pkg holds:
  - the state typedef (4-bit enum, encodings as listed above);
  - the STATE_W=4 constant.
- Sub-module gf180mcu_ocd_io_sync2: 2-flop synchronizer with synchronous reset to 0. Instantiated once each for VDD_PG and DVDD_PG.

Test Plan:
All scenarios use SETTLE_CYC=4, TIMEOUT_CYC=20, ISO_DLY=3.
- Power-up: RST then PWR_REQ=1; VDD_PG rises 5 cycles after VDD_EN; DVDD_PG rises 5 cycles after DVDD_EN -> STATE steps 0,1,2,3,4,5,6. Once PWR_RDY=1 and ISO_N=1, STATE reaches ON. From DVDD_PG rising: 2 synchronizer cycles + 4 + 3 + 1 transition cycle.
- Power-down from ON: PWR_REQ=0 -> ISO_N=0 and PWR_RDY=0 next cycle. DVDD_EN falls 3 cycles later; VDD_EN falls 4 cycles after that; STATE=OFF 4 cycles later.
- Timeout: PWR_REQ=1, VDD_PG held 0 -> FAULT=1 and VDD_EN=0 exactly 20 cycles after entering CORE_UP. Then FAULT_CLR with PWR_REQ=1 -> stays FLT. FAULT_CLR with PWR_REQ=0 -> OFF, FAULT=0.
- Brown-out: in ON, drop DVDD_PG -> FLT 3 cycles later (2 sync + 1); all enables 0, ISO_N=0.
- Abort mid-ramp: PWR_REQ=0 while in IO_SET -> IO_DN next cycle, DVDD_EN=0, then CORE_DN, then OFF. ISO_N stays 0 throughout.
- Reset mid-sequence: assert RST in ISO_REL -> next cycle all outputs at reset values, STATE=OFF.

Source files
------------

// File: rtl/gf180mcu_ocd_io_pwrseq_pkg.sv
// Shared types for the IO ring power sequencer.
package gf180mcu_ocd_io_pwrseq_pkg;

   localparam int STATE_W = 4;

   // Encodings are visible on the STATE debug port and must stay fixed.
   typedef enum logic [STATE_W-1:0] {
      st_off      = 4'd0,
      st_core_up  = 4'd1,
      st_core_set = 4'd2,
      st_io_up    = 4'd3,
      st_io_set   = 4'd4,
      st_iso_rel  = 4'd5,
      st_on       = 4'd6,
      st_iso_set  = 4'd7,
      st_io_dn    = 4'd8,
      st_core_dn  = 4'd9,
      st_flt      = 4'd10
   } pwr_state_t;

endpackage

// File: rtl/gf180mcu_ocd_io_sync2.sv
// Two-flop synchronizer for the asynchronous power-good comparators.
module gf180mcu_ocd_io_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture; both stages clear on reset so the FSM starts with no power-good.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gf180mcu_ocd_io_pwrseq.sv
// Power-up/power-down sequencer for one IO ring segment (VDD core rail, DVDD IO rail).
module gf180mcu_ocd_io_pwrseq
   import gf180mcu_ocd_io_pwrseq_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 100,
   parameter int TIMEOUT_CYC = 1000,
   parameter int ISO_DLY     = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               PWR_REQ,
   input  logic               FAULT_CLR,
   input  logic               VDD_PG,
   input  logic               DVDD_PG,
   output logic               VDD_EN,
   output logic               DVDD_EN,
   output logic               ISO_N,
   output logic               PWR_RDY,
   output logic               FAULT,
   output logic [STATE_W-1:0] STATE
);

   // A wait of N cycles ends on the cycle the shared counter reads N-1.
   localparam logic [CNT_W-1:0] settle_end  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] timeout_end = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] iso_end     = CNT_W'(ISO_DLY - 1);

   pwr_state_t       state;
   pwr_state_t       nxt;
   logic [CNT_W-1:0] cnt;
   logic             vpg;
   logic             dpg;

   gf180mcu_ocd_io_sync2 u_sync_vpg (
      .clk (CLK),
      .rst (RST),
      .d   (VDD_PG),
      .q   (vpg)
   );

   gf180mcu_ocd_io_sync2 u_sync_dpg (
      .clk (CLK),
      .rst (RST),
      .d   (DVDD_PG),
      .q   (dpg)
   );

   // Next-state selection; power-good loss outranks a request drop, which outranks step completion.
   always_comb begin
      nxt = state;
      unique case (state)
         st_off: begin
            if (PWR_REQ) nxt = st_core_up;
         end
         st_core_up: begin
            if (!PWR_REQ)                nxt = st_core_dn;
            else if (vpg)                nxt = st_core_set;
            else if (cnt == timeout_end) nxt = st_flt;
         end
         st_core_set: begin
            if (!vpg)                   nxt = st_flt;
            else if (!PWR_REQ)          nxt = st_core_dn;
            else if (cnt == settle_end) nxt = st_io_up;
         end
         st_io_up: begin
            if (!vpg)                    nxt = st_flt;
            else if (!PWR_REQ)           nxt = st_io_dn;
            else if (dpg)                nxt = st_io_set;
            else if (cnt == timeout_end) nxt = st_flt;
         end
         st_io_set: begin
            if (!vpg)                   nxt = st_flt;
            else if (!PWR_REQ)          nxt = st_io_dn;
            else if (cnt == settle_end) nxt = st_iso_rel;
         end
         st_iso_rel: begin
            if (!vpg)                nxt = st_flt;
            else if (!PWR_REQ)       nxt = st_io_dn;
            else if (cnt == iso_end) nxt = st_on;
         end
         st_on: begin
            if (!vpg || !dpg)  nxt = st_flt;
            else if (!PWR_REQ) nxt = st_iso_set;
         end
         st_iso_set: begin
            if (cnt == iso_end) nxt = st_io_dn;
         end
         st_io_dn: begin
            if (cnt == settle_end) nxt = st_core_dn;
         end
         st_core_dn: begin
            if (cnt == settle_end) nxt = st_off;
         end
         st_flt: begin
            if (FAULT_CLR && !PWR_REQ) nxt = st_off;
         end
         default: nxt = st_off;
      endcase
   end

   // State, step counter and Moore outputs decoded from the state being entered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= st_off;
         cnt     <= '0;
         VDD_EN  <= 1'b0;
         DVDD_EN <= 1'b0;
         ISO_N   <= 1'b0;
         PWR_RDY <= 1'b0;
         FAULT   <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= (nxt != state) ? '0 : cnt + 1'b1;
         VDD_EN  <= nxt inside {st_core_up, st_core_set, st_io_up, st_io_set,
                                st_iso_rel, st_on, st_iso_set, st_io_dn};
         DVDD_EN <= nxt inside {st_io_up, st_io_set, st_iso_rel, st_on, st_iso_set};
         ISO_N   <= (nxt == st_on);
         PWR_RDY <= (nxt == st_on);
         FAULT   <= (nxt == st_flt);
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_gf180mcu_ocd_io_pwrseq.sv
// Scoreboard bench: driver runs a step-table reference model and queues expected outputs,
// a negedge monitor pops and compares.
module tb_gf180mcu_ocd_io_pwrseq;

   localparam int SET = 4;
   localparam int TO  = 20;
   localparam int ISD = 3;

   logic       CLK = 1'b0;
   logic       RST, PWR_REQ, FAULT_CLR, VDD_PG, DVDD_PG;
   logic       VDD_EN, DVDD_EN, ISO_N, PWR_RDY, FAULT;
   logic [3:0] STATE;

   gf180mcu_ocd_io_pwrseq #(
      .CNT_W       (16),
      .SETTLE_CYC  (SET),
      .TIMEOUT_CYC (TO),
      .ISO_DLY     (ISD)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .PWR_REQ   (PWR_REQ),
      .FAULT_CLR (FAULT_CLR),
      .VDD_PG    (VDD_PG),
      .DVDD_PG   (DVDD_PG),
      .VDD_EN    (VDD_EN),
      .DVDD_EN   (DVDD_EN),
      .ISO_N     (ISO_N),
      .PWR_RDY   (PWR_RDY),
      .FAULT     (FAULT),
      .STATE     (STATE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] st;
      logic       v;
      logic       d;
      logic       iso;
      logic       rdy;
      logic       flt;
   } obs_t;

   obs_t expq[$];
   int   tests = 0;
   int   fails = 0;

   // Step description table, indexed by the debug state number (0..10).
   int wait_len [0:10] = '{0, 0, SET, 0, SET, ISD, 0, ISD, SET, SET, 0};
   int next_ok  [0:10] = '{1, 2, 3, 4, 5, 6, 6, 8, 9, 0, 10};
   int abort_to [0:10] = '{-1, 9, 9, 8, 8, 8, 7, -1, -1, -1, -1};
   int pg_wait  [0:10] = '{0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0};
   bit v_guard  [0:10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   bit out_v    [0:10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
   bit out_d    [0:10] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};

   // Reference model state: step, edge it was entered on, current edge, delayed power-good.
   int mst = 0;
   int ment = 0;
   int k = 0;
   bit mv1 = 0, mv2 = 0, md1 = 0, md2 = 0;

   // Rail emulation knobs and state.
   int vramp = 0, dramp = 0, vdly = 1, ddly = 1, vdrop = 0, ddrop = 0;
   int fixed_dly = 0;
   bit no_vpg = 0, d_low = 0, rnd_drop = 0;

   function automatic int ref_next(int s, int el, bit req, bit clr, bit vs, bit ds);
      if (s == 10) return (clr && !req) ? 0 : 10;
      if (s == 0) return req ? 1 : 0;
      if (v_guard[s] && !vs) return 10;
      if (s == 6 && !ds) return 10;
      if (abort_to[s] >= 0 && !req) return abort_to[s];
      if (pg_wait[s] != 0) begin
         if ((pg_wait[s] == 1) ? vs : ds) return next_ok[s];
         return (el == TO) ? 10 : s;
      end
      if (wait_len[s] != 0 && el == wait_len[s]) return next_ok[s];
      return s;
   endfunction

   function automatic int pick_dly();
      if (fixed_dly > 0) return fixed_dly;
      if ($urandom_range(0, 7) == 0) return 25;
      return int'($urandom_range(1, 8));
   endfunction

   task automatic rail(output bit pv, output bit pd);
      if (out_v[mst]) vramp++;
      else begin
         vramp = 0;
         vdly  = pick_dly();
      end
      if (out_d[mst]) dramp++;
      else begin
         dramp = 0;
         ddly  = pick_dly();
      end
      if (rnd_drop && vdrop == 0 && $urandom_range(0, 299) == 0) vdrop = int'($urandom_range(1, 4));
      if (rnd_drop && ddrop == 0 && $urandom_range(0, 299) == 0) ddrop = int'($urandom_range(1, 4));
      pv = out_v[mst] && vramp >= vdly && vdrop == 0 && !no_vpg;
      pd = out_d[mst] && dramp >= ddly && ddrop == 0 && !d_low;
      if (vdrop > 0) vdrop--;
      if (ddrop > 0) ddrop--;
   endtask

   // Drive one cycle of inputs, advance the model across the coming edge, queue its outputs.
   task automatic cyc(input bit rst, input bit req, input bit clr);
      bit   pv, pd;
      int   ns;
      obs_t e;
      rail(pv, pd);
      RST = rst; PWR_REQ = req; FAULT_CLR = clr; VDD_PG = pv; DVDD_PG = pd;
      k++;
      if (rst) begin
         mst = 0; ment = k;
         mv1 = 0; mv2 = 0; md1 = 0; md2 = 0;
      end else begin
         ns  = ref_next(mst, k - ment, req, clr, mv2, md2);
         mv2 = mv1; mv1 = pv;
         md2 = md1; md1 = pd;
         if (ns != mst) begin
            mst  = ns;
            ment = k;
         end
      end
      e.st  = 4'(mst);
      e.v   = out_v[mst];
      e.d   = out_d[mst];
      e.iso = (mst == 6);
      e.rdy = (mst == 6);
      e.flt = (mst == 10);
      expq.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_for(input int target);
      int n;
      n = 0;
      while (mst != target && n < 200) begin
         cyc(0, 1, 0);
         n++;
      end
      tests++;
      if (mst != target) begin
         fails++;
         $display("FAIL reach_state: model at %0d after %0d cycles, required %0d", mst, n, target);
      end
   endtask

   // Monitor: one observation per clock, compared against the oldest queued expectation.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge CLK);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {STATE, VDD_EN, DVDD_EN, ISO_N, PWR_RDY, FAULT};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs t=%0t: got st=%0d vdd=%b dvdd=%b iso=%b rdy=%b flt=%b, required st=%0d vdd=%b dvdd=%b iso=%b rdy=%b flt=%b",
                        $time, a.st, a.v, a.d, a.iso, a.rdy, a.flt,
                        e.st, e.v, e.d, e.iso, e.rdy, e.flt);
            end
         end
      end
   end

   initial begin
      bit req;
      RST = 1'b1; PWR_REQ = 1'b0; FAULT_CLR = 1'b0; VDD_PG = 1'b0; DVDD_PG = 1'b0;
      req = 1'b0;
      #1;
      repeat (3) cyc(1, 0, 0);

      // Full power-up with rails answering 5 cycles after enable, then power-down.
      fixed_dly = 5;
      repeat (70) cyc(0, 1, 0);
      repeat (40) cyc(0, 0, 0);

      // Core rail never good: timeout, ignored clear, accepted clear.
      no_vpg = 1;
      repeat (30) cyc(0, 1, 0);
      cyc(0, 1, 1);
      repeat (3) cyc(0, 1, 0);
      cyc(0, 0, 1);
      repeat (3) cyc(0, 0, 0);
      no_vpg = 0;

      // Brown-out of the IO rail while ON.
      repeat (70) cyc(0, 1, 0);
      d_low = 1;
      repeat (8) cyc(0, 1, 0);
      d_low = 0;
      cyc(0, 0, 1);
      repeat (3) cyc(0, 0, 0);

      // Abort during IO_SET.
      wait_for(4);
      repeat (30) cyc(0, 0, 0);

      // Reset during ISO_REL.
      wait_for(5);
      cyc(1, 1, 0);
      repeat (5) cyc(0, 0, 0);

      // Randomized requests, clears, resets, rail delays and brown-outs.
      fixed_dly = 0;
      rnd_drop  = 1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 59) == 0) req = !req;
         cyc(($urandom_range(0, 399) == 0), req, ($urandom_range(0, 9) == 0));
      end

      @(negedge CLK);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
